// File: rtl/mem_access_unit_if.sv
// Load/store unit port bundle: the requester-facing handshake plus the
// multi-cycle data bus. The unit itself takes the "slave" view; whoever
// drives requests and answers the bus (execute stage + memory, or a bench)
// takes the "master" view.
interface mem_access_unit_if #(
    parameter int XLEN = 32
);
    localparam int NB = XLEN / 8;

    // Requester side
    logic            available;
    logic            is_write;
    logic            is_unsigned;
    logic [1:0]      op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] out;
    logic            op_fault;
    logic            addr_fault;
    logic            access_fault;

    // Data bus side
    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [NB-1:0]   bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_ack;
    logic            bus_err;
    logic [XLEN-1:0] bus_rdata;

    modport slave (
        input  available, is_write, is_unsigned, op, addr, in,
        output busy, done, out, op_fault, addr_fault, access_fault,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );

    modport master (
        output available, is_write, is_unsigned, op, addr, in,
        input  busy, done, out, op_fault, addr_fault, access_fault,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit. Accepts one access in IDLE, decodes size and
// alignment, runs a request/acknowledge bus transfer with byte lanes and a
// timeout watchdog, then presents extended load data or a fault for a single
// DONE cycle.
module mem_access_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    mem_access_unit_if.slave io
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    // The counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic            busy_q;
    logic            done_q;
    logic            op_fault_q;
    logic            addr_fault_q;
    logic            access_fault_q;
    logic [XLEN-1:0] out_q;
    logic            bus_req_q;
    logic            bus_we_q;
    logic [XLEN-1:0] bus_addr_q;
    logic [NB-1:0]   bus_be_q;
    logic [XLEN-1:0] bus_wdata_q;
    logic            is_unsigned_q;
    logic [1:0]      op_q;
    logic [OFFW-1:0] off_q;
    logic [CW-1:0]   cnt_q;

    // ---------------------------------------------------------------
    // Acceptance-time decode (combinational on the requester inputs)
    // ---------------------------------------------------------------
    logic [OFFW-1:0] off_d;
    logic [NB-1:0]   be_base_d;
    logic [NB-1:0]   be_d;
    logic [XLEN-1:0] wdata_d;
    logic [XLEN-1:0] baddr_d;
    logic            op_invalid_d;
    logic            misaligned_d;

    assign off_d = io.addr[OFFW-1:0];

    // Size mask before lane shift: 1, 3, F or FF lanes.
    for (genvar gi = 0; gi < NB; gi++) begin : g_be_base
        assign be_base_d[gi] = (gi < (1 << io.op));
    end

    assign be_d         = be_base_d << off_d;
    assign wdata_d      = io.in << {off_d, 3'b000};
    assign baddr_d      = {io.addr[XLEN-1:OFFW], {OFFW{1'b0}}};
    assign op_invalid_d = (io.op == 2'b11) && (XLEN == 32);

    // Natural alignment check for the requested size
    always_comb begin
        misaligned_d = 1'b0;
        case (io.op)
            2'b01:   misaligned_d = io.addr[0];
            2'b10:   misaligned_d = |io.addr[1:0];
            2'b11:   misaligned_d = |io.addr[2:0];
            default: misaligned_d = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------
    // Load extraction from the full-width read word (latched size/lane)
    // ---------------------------------------------------------------
    logic [XLEN-1:0] shifted_d;
    logic [XLEN-1:0] ext_mask_d;
    logic [XLEN-1:0] load_d;
    logic            sign_d;

    assign shifted_d = io.bus_rdata >> {off_q, 3'b000};

    // Bits belonging to the access size; a full-XLEN access yields all ones,
    // so the extension term below vanishes and is_unsigned has no effect.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext_mask
        assign ext_mask_d[gi] = (gi < (8 << op_q));
    end

    // Sign bit of the truncated value; irrelevant for full-width sizes
    always_comb begin
        sign_d = 1'b0;
        case (op_q)
            2'b00:   sign_d = shifted_d[7];
            2'b01:   sign_d = shifted_d[15];
            default: sign_d = shifted_d[31];
        endcase
    end

    assign load_d = (shifted_d & ext_mask_d)
                  | ((sign_d && !is_unsigned_q) ? ~ext_mask_d : '0);

    // ---------------------------------------------------------------
    // Control FSM with registered outputs
    // ---------------------------------------------------------------
    // Sequences accept -> bus transfer -> one-cycle completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            op_fault_q     <= 1'b0;
            addr_fault_q   <= 1'b0;
            access_fault_q <= 1'b0;
            out_q          <= '0;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_be_q       <= '0;
            bus_wdata_q    <= '0;
            is_unsigned_q  <= 1'b0;
            op_q           <= 2'b00;
            off_q          <= '0;
            cnt_q          <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.available) begin
                        is_unsigned_q <= io.is_unsigned;
                        op_q          <= io.op;
                        off_q         <= off_d;
                        busy_q        <= 1'b1;
                        cnt_q         <= '0;
                        if (op_invalid_d) begin
                            // Size fault wins over alignment; bus untouched.
                            op_fault_q <= 1'b1;
                            done_q     <= 1'b1;
                            state_q    <= DONE;
                        end else if (misaligned_d) begin
                            addr_fault_q <= 1'b1;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end else begin
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= io.is_write;
                            bus_addr_q  <= baddr_d;
                            bus_be_q    <= be_d;
                            bus_wdata_q <= wdata_d;
                            state_q     <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (io.bus_err) begin
                        // Error outranks a simultaneous acknowledge.
                        access_fault_q <= 1'b1;
                        bus_req_q      <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= DONE;
                    end else if (io.bus_ack) begin
                        if (!bus_we_q) begin
                            out_q <= load_d;
                        end
                        bus_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
                        access_fault_q <= 1'b1;
                        bus_req_q      <= 1'b0;
                        done_q         <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    done_q         <= 1'b0;
                    busy_q         <= 1'b0;
                    op_fault_q     <= 1'b0;
                    addr_fault_q   <= 1'b0;
                    access_fault_q <= 1'b0;
                    state_q        <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign io.busy         = busy_q;
    assign io.done         = done_q;
    assign io.out          = out_q;
    assign io.op_fault     = op_fault_q;
    assign io.addr_fault   = addr_fault_q;
    assign io.access_fault = access_fault_q;
    assign io.bus_req      = bus_req_q;
    assign io.bus_we       = bus_we_q;
    assign io.bus_addr     = bus_addr_q;
    assign io.bus_be       = bus_be_q;
    assign io.bus_wdata    = bus_wdata_q;
endmodule
